// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - pipeline control shared types and constants
package pipe_ctrl_pkg;

    localparam int          MDU_TIMEOUT_DEF = 64;
    localparam logic [31:0] INST_NOP        = 32'h0000_0013;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/dff_set.sv
// rtl/dff_set.sv - register with synchronous active-low load of a set value
module dff_set #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] set_data,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_o <= set_data;
        end else begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush/redirect control with MDU wait sequencing
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        load_use_i,
    input  logic        mdu_req_i,
    input  logic        mdu_done_i,
    input  logic        bus_wait_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        stall_pc_o,
    output logic        stall_if_id_o,
    output logic        stall_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        mdu_busy_o,
    output logic        timeout_err_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    localparam int            TW   = $clog2(MDU_TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(MDU_TIMEOUT - 1);

    ctrl_state_e   state, state_nxt;
    logic [0:0]    state_q, state_d;
    logic [0:0]    err_q, err_d;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_clr, tmo_hit;
    logic [31:0]   stall_cnt, flush_cnt;

    assign state   = ctrl_state_e'(state_q);
    assign state_d = state_nxt;
    assign err_d   = err_q | tmo_hit;

    dff_set #(.DW(1)) u_state_reg (
        .clk      (clk),
        .rst      (rst),
        .set_data (1'b0),
        .data_i   (state_d),
        .data_o   (state_q)
    );

    dff_set #(.DW(1)) u_err_reg (
        .clk      (clk),
        .rst      (rst),
        .set_data (1'b0),
        .data_i   (err_d),
        .data_o   (err_q)
    );

    always_comb begin
        state_nxt     = state;
        jump_en_o     = 1'b0;
        jump_addr_o   = 32'b0;
        stall_pc_o    = 1'b0;
        stall_if_id_o = 1'b0;
        stall_id_ex_o = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        mdu_busy_o    = 1'b0;
        tmo_clr       = 1'b0;
        tmo_hit       = 1'b0;
        case (state)
            ST_RUN: begin
                if (jump_en_i) begin
                    jump_en_o     = 1'b1;
                    jump_addr_o   = jump_addr_i;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end else if (mdu_req_i) begin
                    // A same-cycle done means the op finished in EX without waiting.
                    if (!mdu_done_i) begin
                        stall_pc_o    = 1'b1;
                        stall_if_id_o = 1'b1;
                        stall_id_ex_o = 1'b1;
                        tmo_clr       = 1'b1;
                        state_nxt     = ST_MDU_WAIT;
                    end
                end else if (load_use_i) begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end else if (bus_wait_i) begin
                    stall_pc_o    = 1'b1;
                    flush_if_id_o = 1'b1;
                end
            end
            ST_MDU_WAIT: begin
                mdu_busy_o = 1'b1;
                if (mdu_done_i) begin
                    state_nxt = ST_RUN;
                end else if (tmo_cnt == TMAX) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    stall_id_ex_o = 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
        // Reset forces every strobe low even though the state register is stale.
        if (!rst) begin
            jump_en_o     = 1'b0;
            jump_addr_o   = 32'b0;
            stall_pc_o    = 1'b0;
            stall_if_id_o = 1'b0;
            stall_id_ex_o = 1'b0;
            flush_if_id_o = 1'b0;
            flush_id_ex_o = 1'b0;
            mdu_busy_o    = 1'b0;
            tmo_hit       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (tmo_clr) begin
            tmo_cnt <= '0;
        end else if (state == ST_MDU_WAIT && tmo_cnt != TMAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= 32'd0;
        end else if (stall_pc_o) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            flush_cnt <= 32'd0;
        end else if (jump_en_o) begin
            flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign timeout_err_o = rst & err_q[0];
    assign stall_cnt_o   = rst ? stall_cnt : 32'd0;
    assign flush_cnt_o   = rst ? flush_cnt : 32'd0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        load_use_i;
    logic        mdu_req_i;
    logic        mdu_done_i;
    logic        bus_wait_i;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        stall_pc_o;
    logic        stall_if_id_o;
    logic        stall_id_ex_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        mdu_busy_o;
    logic        timeout_err_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MDU_TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .load_use_i    (load_use_i),
        .mdu_req_i     (mdu_req_i),
        .mdu_done_i    (mdu_done_i),
        .bus_wait_i    (bus_wait_i),
        .jump_en_o     (jump_en_o),
        .jump_addr_o   (jump_addr_o),
        .stall_pc_o    (stall_pc_o),
        .stall_if_id_o (stall_if_id_o),
        .stall_id_ex_o (stall_id_ex_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o),
        .mdu_busy_o    (mdu_busy_o),
        .timeout_err_o (timeout_err_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        jump_en_i   = 1'b0;
        jump_addr_i = 32'h0;
        load_use_i  = 1'b0;
        mdu_req_i   = 1'b0;
        mdu_done_i  = 1'b0;
        bus_wait_i  = 1'b0;
    endtask

    task automatic chk_strobes(input string tag, input logic [6:0] exp);
        chk(tag, {jump_en_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
                  flush_if_id_o, flush_id_ex_o, mdu_busy_o}, {25'b0, exp});
    endtask

    initial begin
        // strobe vector order: jump_en, stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, mdu_busy
        rst = 1'b0;
        idle_inputs();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h55;
        mdu_req_i   = 1'b1;
        bus_wait_i  = 1'b1;
        #2;
        chk_strobes("rst_strobes_pre", 7'b0000000);
        chk("rst_addr_pre", jump_addr_o, 32'h0);
        cyc();
        cyc();
        #3;
        chk_strobes("rst_strobes", 7'b0000000);
        chk("rst_stall_cnt", stall_cnt_o, 32'd0);
        chk("rst_flush_cnt", flush_cnt_o, 32'd0);
        chk("rst_err", {31'b0, timeout_err_o}, 32'd0);

        cyc();
        rst = 1'b1;
        idle_inputs();
        #3;
        chk_strobes("idle", 7'b0000000);
        chk("idle_addr", jump_addr_o, 32'h0);

        cyc();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0100;
        #3;
        chk_strobes("jump", 7'b1000110);
        chk("jump_addr", jump_addr_o, 32'h100);
        chk("jump_flush_cnt_before", flush_cnt_o, 32'd0);
        cyc();
        idle_inputs();
        #3;
        chk("jump_flush_cnt_after", flush_cnt_o, 32'd1);
        chk("jump_addr_idle", jump_addr_o, 32'h0);

        load_use_i = 1'b1;
        bus_wait_i = 1'b1;
        #1;
        chk_strobes("load_use", 7'b0110010);
        cyc();
        load_use_i = 1'b0;
        #3;
        chk_strobes("bus_wait", 7'b0100100);
        chk("lu_stall_cnt", stall_cnt_o, 32'd1);
        cyc();
        bus_wait_i = 1'b0;
        #3;
        chk_strobes("after_bus_wait", 7'b0000000);
        chk("bw_stall_cnt", stall_cnt_o, 32'd2);

        mdu_req_i = 1'b1;
        #1;
        chk_strobes("mdu_c0", 7'b0111000);
        cyc();
        mdu_req_i = 1'b0;
        #3;
        chk_strobes("mdu_c1", 7'b0111001);
        cyc();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h200;
        #3;
        chk_strobes("mdu_c2_jump_ignored", 7'b0111001);
        chk("mdu_c2_addr", jump_addr_o, 32'h0);
        cyc();
        jump_en_i   = 1'b0;
        jump_addr_i = 32'h0;
        #3;
        chk_strobes("mdu_c3", 7'b0111001);
        cyc();
        mdu_done_i = 1'b1;
        #3;
        chk("mdu_c4_stalls", {29'b0, stall_pc_o, stall_if_id_o, stall_id_ex_o}, 32'd0);
        cyc();
        mdu_done_i = 1'b0;
        #3;
        chk_strobes("mdu_c5", 7'b0000000);
        chk("mdu_stall_cnt", stall_cnt_o, 32'd6);
        chk("mdu_flush_cnt", flush_cnt_o, 32'd1);

        mdu_req_i  = 1'b1;
        mdu_done_i = 1'b1;
        #1;
        chk_strobes("mdu_l0", 7'b0000000);
        cyc();
        idle_inputs();
        #3;
        chk_strobes("mdu_l0_next", 7'b0000000);
        chk("mdu_l0_stall_cnt", stall_cnt_o, 32'd6);

        jump_en_i   = 1'b1;
        jump_addr_i = 32'h300;
        mdu_req_i   = 1'b1;
        #1;
        chk_strobes("jump_vs_mdu", 7'b1000110);
        chk("jump_vs_mdu_addr", jump_addr_o, 32'h300);
        cyc();
        idle_inputs();
        #3;
        chk_strobes("jump_vs_mdu_next", 7'b0000000);
        chk("jump_vs_mdu_flush_cnt", flush_cnt_o, 32'd2);
        chk("jump_vs_mdu_stall_cnt", stall_cnt_o, 32'd6);

        mdu_req_i = 1'b1;
        #1;
        chk_strobes("tmo_req", 7'b0111000);
        for (int k = 1; k <= 7; k++) begin
            cyc();
            mdu_req_i = 1'b0;
            #3;
            chk_strobes($sformatf("tmo_wait%0d", k), 7'b0111001);
            chk($sformatf("tmo_wait%0d_err", k), {31'b0, timeout_err_o}, 32'd0);
        end
        cyc();
        #3;
        chk_strobes("tmo_exit", 7'b0000001);
        chk("tmo_exit_err", {31'b0, timeout_err_o}, 32'd0);
        cyc();
        #3;
        chk_strobes("tmo_run", 7'b0000000);
        chk("tmo_err_set", {31'b0, timeout_err_o}, 32'd1);
        chk("tmo_stall_cnt", stall_cnt_o, 32'd14);
        load_use_i = 1'b1;
        #1;
        chk_strobes("tmo_then_lu", 7'b0110010);
        cyc();
        load_use_i = 1'b0;
        #3;
        chk("tmo_err_held", {31'b0, timeout_err_o}, 32'd1);
        chk("tmo_lu_stall_cnt", stall_cnt_o, 32'd15);

        mdu_req_i = 1'b1;
        cyc();
        mdu_req_i = 1'b0;
        cyc();
        rst = 1'b0;
        #3;
        chk_strobes("rst_mid_wait", 7'b0000000);
        chk("rst_mid_err", {31'b0, timeout_err_o}, 32'd0);
        chk("rst_mid_stall_cnt", stall_cnt_o, 32'd0);
        cyc();
        rst = 1'b1;
        #3;
        chk_strobes("post_rst", 7'b0000000);
        chk("post_rst_stall_cnt", stall_cnt_o, 32'd0);
        chk("post_rst_flush_cnt", flush_cnt_o, 32'd0);
        chk("post_rst_err", {31'b0, timeout_err_o}, 32'd0);
        mdu_req_i = 1'b1;
        #1;
        chk_strobes("post_rst_req", 7'b0111000);
        cyc();
        mdu_req_i = 1'b0;
        #3;
        chk_strobes("post_rst_wait", 7'b0111001);
        cyc();
        mdu_done_i = 1'b1;
        #3;
        chk("post_rst_done_stall", {31'b0, stall_pc_o}, 32'd0);
        cyc();
        mdu_done_i = 1'b0;
        #3;
        chk_strobes("post_rst_run", 7'b0000000);
        chk("post_rst_req_stall_cnt", stall_cnt_o, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
